// File: rtl/alu_bit_slice.sv
// ---------------------------------------------------------------------------
// alu_bit_slice
//   Registered bit-slice ALU: a ripple chain of WIDTH one-bit slices, each
//   built from a fullAdder, a mux2_1 (B or ~B, chosen by sel[0]) and a mux8_1
//   result selector. Results and flags are registered with one-cycle latency.
//
//   Operations (sel):
//     000 R=B   010 R=A+B+cin   011 R=A+~B+cin   100 R=A&B
//     101 R=A|B 110 R=A^B       001/111 R=0
//   cin is passed through untouched; subtraction is two's complement only
//   when the caller drives cin=1.
//
//   Optional feature macro: ALU_BIT_SLICE_FLAGS_EN
//     defined   -> zero/negative/overflow flags are computed and registered
//     undefined -> zero/negative/overflow tied to 0, their logic omitted
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset (priority over in_valid)
//   in_valid   in   A/B/cin/sel valid this cycle
//   A, B       in   operands [WIDTH-1:0]
//   cin        in   carry into bit 0
//   sel        in   operation select [2:0]
//   out_valid  out  registered result valid
//   R          out  registered result [WIDTH-1:0]
//   cout       out  registered carry out of MSB (arith ops only)
//   overflow   out  registered signed overflow (arith ops only)
//   zero       out  registered R==0
//   negative   out  registered R[WIDTH-1]
// ---------------------------------------------------------------------------

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module mux2_1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module mux8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);
  assign y = d[sel];
endmodule

module alu_bit_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [2:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] R,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] slice_r;
  logic             is_arith;

  assign carry[0] = cin;
  assign is_arith = (sel[2:1] == 2'b01);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic b_sel;
    logic sum;

    mux2_1 u_bmux (
      .d0  (B[i]),
      .d1  (~B[i]),
      .sel (sel[0]),
      .y   (b_sel)
    );

    fullAdder u_fa (
      .a    (A[i]),
      .b    (b_sel),
      .cin  (carry[i]),
      .sum  (sum),
      .cout (carry[i+1])
    );

    // Both 010 and 011 select the adder; sel[0] already chose B or ~B.
    mux8_1 u_rmux (
      .d   ({1'b0, A[i] ^ B[i], A[i] | B[i], A[i] & B[i],
             sum, sum, 1'b0, B[i]}),
      .sel (sel),
      .y   (slice_r[i])
    );
  end

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] r_d, r_q;
  logic             cout_d, cout_q;

  always_comb begin
    valid_d = in_valid;
    r_d     = r_q;
    cout_d  = cout_q;
    if (in_valid) begin
      r_d    = slice_r;
      cout_d = is_arith & carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      r_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      r_q     <= r_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign R         = r_q;
  assign cout      = cout_q;

`ifdef ALU_BIT_SLICE_FLAGS_EN
  logic overflow_d, overflow_q;
  logic zero_d, zero_q;
  logic negative_d, negative_q;

  always_comb begin
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    if (in_valid) begin
      overflow_d = is_arith & (carry[WIDTH-1] ^ carry[WIDTH]);
      zero_d     = (slice_r == '0);
      negative_d = slice_r[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bit_slice.sv
// ---------------------------------------------------------------------------
// tb_alu_bit_slice
//   Self-checking bench for alu_bit_slice: an 8-bit instance driven with
//   directed cases and random traffic, and a 1-bit instance swept over every
//   {sel,A,B,cin} combination. Expected values come from an arithmetic
//   reference model. Flag expectations follow ALU_BIT_SLICE_FLAGS_EN.
// ---------------------------------------------------------------------------

module tb_alu_bit_slice;

`ifdef ALU_BIT_SLICE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 8-bit instance
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [2:0] s8;
  logic       ov8_valid, co8, vf8, z8, n8;
  logic [7:0] r8;

  // 1-bit instance
  logic       v1, c1;
  logic [0:0] a1, b1;
  logic [2:0] s1;
  logic       ov1_valid, co1, vf1, z1, n1;
  logic [0:0] r1;

  alu_bit_slice #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .A(a8), .B(b8), .cin(c8),
    .sel(s8), .out_valid(ov8_valid), .R(r8), .cout(co8), .overflow(vf8),
    .zero(z8), .negative(n8)
  );

  alu_bit_slice #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .A(a1), .B(b1), .cin(c1),
    .sel(s1), .out_valid(ov1_valid), .R(r1), .cout(co1), .overflow(vf1),
    .zero(z1), .negative(n1)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int unsigned w, input logic [2:0] s,
                                input longint unsigned a, input longint unsigned b,
                                input bit ci, output longint unsigned r,
                                output bit co, output bit ov);
    longint unsigned mask, bb, full;
    longint sa, sb, ssum, lim;
    mask = (64'd1 << w) - 1;
    r = 0; co = 0; ov = 0;
    case (s)
      3'd0: r = b;
      3'd2, 3'd3: begin
        bb   = (s == 3'd3) ? (~b & mask) : b;
        full = a + bb + longint'(ci);
        r    = full & mask;
        co   = ((full >> w) & 1) != 0;
        lim  = longint'(64'd1 << (w - 1));
        sa   = (a >= longint'(lim)) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (bb >= longint'(lim)) ? longint'(bb) - 2 * lim : longint'(bb);
        ssum = sa + sb + longint'(ci);
        ov   = (ssum >= lim) || (ssum < -lim);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 0;
    endcase
  endfunction

  // Expected registered state of the 8-bit instance
  bit       e_valid, e_co, e_ov, e_z, e_n;
  bit [7:0] e_r;

  task automatic check8(input string tag);
    chk({tag, "_valid"}, 64'(ov8_valid), 64'(e_valid));
    chk({tag, "_r"},     64'(r8),        64'(e_r));
    chk({tag, "_cout"},  64'(co8),       64'(e_co));
    chk({tag, "_ovf"},   64'(vf8),       64'(e_ov));
    chk({tag, "_zero"},  64'(z8),        64'(e_z));
    chk({tag, "_neg"},   64'(n8),        64'(e_n));
  endtask

  // Apply one cycle to the 8-bit instance, advance the model, check outputs.
  task automatic step8(input string tag, input bit rst, input bit vin,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit ci, input logic [2:0] s);
    longint unsigned r;
    bit co, ov;
    reset = rst; v8 = vin; a8 = a; b8 = b; c8 = ci; s8 = s;
    v1 = 1'b0;
    model(8, s, longint'(a), longint'(b), ci, r, co, ov);
    if (rst) begin
      e_valid = 0; e_r = 0; e_co = 0; e_ov = 0; e_z = 0; e_n = 0;
    end else if (vin) begin
      e_valid = 1; e_r = r[7:0]; e_co = co;
      e_ov = FLAGS_ON & ov;
      e_z  = FLAGS_ON & (r[7:0] == 8'h00);
      e_n  = FLAGS_ON & r[7];
    end else begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    check8(tag);
  endtask

  initial begin
    logic [2:0] sels [6];
    logic [7:0] rexp [6];
    reset = 1'b1; v8 = 0; a8 = 0; b8 = 0; c8 = 0; s8 = 0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0; s1 = 0;
    @(posedge clk);
    #1;

    // Reset dominates a valid operation presented in the same cycle.
    step8("rst_ff", 1, 1, 8'hFF, 8'hFF, 0, 3'b010);
    chk("rst_r_const", 64'(r8), 64'h0);
    chk("rst_valid_const", 64'(ov8_valid), 64'h0);

    // Signed overflow on 7F+01
    step8("add_ovf", 0, 1, 8'h7F, 8'h01, 0, 3'b010);
    chk("add_ovf_r_const", 64'(r8), 64'h80);
    chk("add_ovf_cout_const", 64'(co8), 64'h0);

    // 5-5 with cin=1 gives zero and carry
    step8("sub_eq", 0, 1, 8'h05, 8'h05, 1, 3'b011);
    chk("sub_eq_r_const", 64'(r8), 64'h00);
    chk("sub_eq_cout_const", 64'(co8), 64'h1);

    // Non-arithmetic selects on CA/0F
    sels = '{3'b100, 3'b101, 3'b110, 3'b000, 3'b001, 3'b111};
    rexp = '{8'h0A, 8'hCF, 8'hC5, 8'h0F, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      step8($sformatf("logic_s%0d", sels[i]), 0, 1, 8'hCA, 8'h0F, 1, sels[i]);
      chk($sformatf("logic_s%0d_r_const", sels[i]), 64'(r8), 64'(rexp[i]));
      chk($sformatf("logic_s%0d_cout_const", sels[i]), 64'(co8), 64'h0);
    end

    // Unsigned wrap, then an idle cycle must hold R
    step8("wrap", 0, 1, 8'hFF, 8'h01, 0, 3'b010);
    chk("wrap_r_const", 64'(r8), 64'h00);
    chk("wrap_cout_const", 64'(co8), 64'h1);
    step8("idle", 0, 0, 8'h12, 8'h34, 1, 3'b101);
    chk("idle_valid_const", 64'(ov8_valid), 64'h0);
    chk("idle_r_const", 64'(r8), 64'h00);

    // Random traffic with idle cycles and occasional mid-stream resets
    for (int i = 0; i < 300; i++) begin
      step8("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
    end

    // Exhaustive sweep of the 1-bit instance
    v8 = 0; reset = 0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] idx;
      longint unsigned r;
      bit co, ov;
      idx = 6'(i);
      v1 = 1; s1 = idx[5:3]; a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
      model(1, idx[5:3], longint'(idx[2]), longint'(idx[1]), idx[0], r, co, ov);
      @(posedge clk);
      #1;
      chk($sformatf("w1_%0d_valid", i), 64'(ov1_valid), 64'h1);
      chk($sformatf("w1_%0d_r", i),     64'(r1),        64'(r[0]));
      chk($sformatf("w1_%0d_cout", i),  64'(co1),       64'(co));
      chk($sformatf("w1_%0d_ovf", i),   64'(vf1),       64'(FLAGS_ON & ov));
      chk($sformatf("w1_%0d_zero", i),  64'(z1),        64'(FLAGS_ON & (r[0] == 1'b0)));
      chk($sformatf("w1_%0d_neg", i),   64'(n1),        64'(FLAGS_ON & r[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_bit_slice.md
ALU_BIT_SLICE -- requirements
Module: alu_bit_slice

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands/sel valid this cycle.
REQ-005 A  input  WIDTH  first operand.
REQ-006 B  input  WIDTH  second operand.
REQ-007 cin  input  1  carry into bit 0.
REQ-008 sel  input  3  operation select.
REQ-009 out_valid  output  1  registered result valid.
REQ-010 R  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry out of MSB.
REQ-012 overflow  output  1  registered signed overflow.
REQ-013 zero  output  1  registered, high when R==0.
REQ-014 negative  output  1  registered copy of R[WIDTH-1].

Function
REQ-015 Datapath SHALL be a ripple chain of WIDTH one-bit slices, each using a fullAdder, a mux2_1 (B vs ~B, select sel[0]) and a mux8_1 result selector.
REQ-016 sel 000: R=B; 010: R=A+B+cin; 011: R=A+~B+cin; 100: R=A&B; 101: R=A|B; 110: R=A^B; 001 and 111: R=0.
REQ-017 Subtraction is two's complement only when cin=1; the block SHALL NOT force cin.
REQ-018 For sel 010/011, cout = carry out of bit WIDTH-1 and overflow = carry into MSB XOR carry out of MSB; for all other sel, cout=0 and overflow=0.
REQ-019 Sums wrap modulo 2^WIDTH; no saturation.
REQ-020 Latency exactly one cycle: when in_valid=1 at edge N, R/flags reflect those inputs after edge N and out_valid=1.
REQ-021 When in_valid=0 at an edge, out_valid SHALL go 0 and R/cout/overflow/zero/negative SHALL hold their previous values.
REQ-022 No backpressure; a new operation is accepted every cycle.

Reset
REQ-023 When reset=1 at a rising edge, out_valid, R, cout, overflow, zero, negative SHALL all be 0, regardless of in_valid.
REQ-024 Reset has priority over in_valid; an operation presented in the reset cycle is discarded.
REQ-025 First operation accepted on the first edge with reset=0 and in_valid=1.

Configuration
REQ-026 Macro ALU_BIT_SLICE_FLAGS_EN: when defined, zero, negative, overflow are computed per REQ-013/014/018.
REQ-027 When ALU_BIT_SLICE_FLAGS_EN is undefined, zero, negative, overflow SHALL be constant 0 and their logic omitted; R, cout, out_valid unaffected.

Verification (WIDTH=8, flags enabled)
REQ-028 reset=1 with in_valid=1, A=FF, B=FF -> next cycle all outputs 0.
REQ-029 sel=010, A=7F, B=01, cin=0 -> R=80, cout=0, overflow=1, negative=1, zero=0.
REQ-030 sel=011, A=05, B=05, cin=1 -> R=00, cout=1, overflow=0, zero=1.
REQ-031 A=CA, B=0F: sel=100 -> R=0A; 101 -> R=CF; 110 -> R=C5; 000 -> R=0F; 001/111 -> R=00; cout=0, overflow=0 in all.
REQ-032 sel=010, A=FF, B=01, cin=0 -> R=00, cout=1, zero=1, overflow=0; then in_valid=0 -> out_valid=0, R stays 00.
REQ-033 Exhaustive sweep of all 64 {sel,A[0],B[0],cin} combinations at WIDTH=1 against a reference model, one check per cycle.
